// File: rtl/bubble_fetch_decode_if.sv
// Bundles the instruction-memory handshake and the alu operand/result bus of the
// BUBBLE front end. The front end is the master; memory and alu sit on the slave side.
interface bubble_fetch_decode_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [5:0]  alu_opcode;
    logic [4:0]  alu_funct;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_s1;
    logic [31:0] alu_s2;
    logic [15:0] alu_pc;
    logic [15:0] alu_const;
    logic [25:0] alu_jump;
    logic [31:0] alu_dest;
    logic [15:0] alu_pc_new;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_rdata,
        output alu_opcode, alu_funct, alu_shamt, alu_s1, alu_s2, alu_pc, alu_const, alu_jump,
        input  alu_dest, alu_pc_new
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_rdata,
        input  alu_opcode, alu_funct, alu_shamt, alu_s1, alu_s2, alu_pc, alu_const, alu_jump,
        output alu_dest, alu_pc_new
    );
endinterface

// File: rtl/bubble_fetch_decode.sv
// BUBBLE front end: multi-cycle fetch/decode/exec/writeback sequencer with the
// 32x32 register file. Operands are registered in DECODE and held for the alu.
module bubble_fetch_decode #(
    parameter logic [15:0] RESET_PC    = 16'd0,
    parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    bubble_fetch_decode_if.master        bus,
    output logic                         busy,
    output logic                         halted,
    output logic                         illegal,
    output logic [31:0]                  retired,
    input  logic [4:0]                   dbg_addr,
    output logic [31:0]                  dbg_data
);

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StWb, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic [31:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic [31:0] dest_q, dest_d;
    logic [15:0] pc_new_q, pc_new_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [4:0]  funct_q, funct_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [31:0] s1_q, s1_d;
    logic [31:0] s2_q, s2_d;
    logic [15:0] alu_pc_q, alu_pc_d;
    logic [15:0] const_q, const_d;
    logic [25:0] jump_q, jump_d;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [5:0]  ir_opcode;
    logic [4:0]  ir_rs, ir_rt, ir_rd;
    logic [15:0] pc_inc;

    assign ir_opcode = ir_q[31:26];
    assign ir_rs     = ir_q[25:21];
    assign ir_rt     = ir_q[20:16];
    assign ir_rd     = ir_q[15:11];
    assign pc_inc    = pc_q + 16'd1;

    // Next-state, operand capture and writeback selection.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        dest_d    = dest_q;
        pc_new_d  = pc_new_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        shamt_d   = shamt_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        alu_pc_d  = alu_pc_q;
        const_d   = const_q;
        jump_d    = jump_q;
        wr_en     = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (ir_opcode == HALT_OPCODE) begin
                    state_d = StHalt;
                end else if (ir_opcode >= 6'd16) begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    opcode_d = ir_opcode;
                    funct_d  = ir_q[4:0];
                    shamt_d  = ir_q[10:6];
                    // Register 0 reads as zero regardless of array contents.
                    s1_d     = (ir_rs == 5'd0) ? 32'd0 : rf_q[ir_rs];
                    s2_d     = (ir_rt == 5'd0) ? 32'd0 : rf_q[ir_rt];
                    alu_pc_d = pc_inc;
                    const_d  = ir_q[15:0];
                    jump_d   = ir_q[25:0];
                    state_d  = StExec;
                end
            end
            StExec: begin
                dest_d   = bus.alu_dest;
                pc_new_d = bus.alu_pc_new;
                state_d  = StWb;
            end
            StWb: begin
                retired_d = retired_q + 32'd1;
                state_d   = StFetch;
                pc_d      = pc_inc;
                if (ir_opcode == 6'd0) begin
                    wr_en   = 1'b1;
                    wr_addr = ir_rd;
                    wr_data = dest_q;
                end else if (ir_opcode <= 6'd6) begin
                    wr_en   = 1'b1;
                    wr_addr = ir_rt;
                    wr_data = dest_q;
                end else if (ir_opcode <= 6'd14) begin
                    // Branches rely on the alu returning PC+1 when not taken.
                    pc_d = pc_new_q;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = 5'd31;
                    wr_data = {16'd0, pc_inc};
                    pc_d    = pc_new_q;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StIdle;
        endcase

        rf_d = rf_q;
        if (wr_en && (wr_addr != 5'd0)) rf_d[wr_addr] = wr_data;
    end

    // State registers with synchronous reset; reset abandons any outstanding fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
            illegal_q <= 1'b0;
            dest_q    <= 32'd0;
            pc_new_q  <= 16'd0;
            opcode_q  <= 6'd0;
            funct_q   <= 5'd0;
            shamt_q   <= 5'd0;
            s1_q      <= 32'd0;
            s2_q      <= 32'd0;
            alu_pc_q  <= 16'd0;
            const_q   <= 16'd0;
            jump_q    <= 26'd0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            dest_q    <= dest_d;
            pc_new_q  <= pc_new_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            shamt_q   <= shamt_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            alu_pc_q  <= alu_pc_d;
            const_q   <= const_d;
            jump_q    <= jump_d;
            for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
        end
    end

    // Output decode.
    always_comb begin
        bus.imem_req   = (state_q == StFetch);
        bus.imem_addr  = pc_q;
        bus.alu_opcode = opcode_q;
        bus.alu_funct  = funct_q;
        bus.alu_shamt  = shamt_q;
        bus.alu_s1     = s1_q;
        bus.alu_s2     = s2_q;
        bus.alu_pc     = alu_pc_q;
        bus.alu_const  = const_q;
        bus.alu_jump   = jump_q;
        busy           = (state_q == StFetch) || (state_q == StDecode) ||
                         (state_q == StExec) || (state_q == StWb);
        halted         = (state_q == StHalt);
        illegal        = illegal_q;
        retired        = retired_q;
        dbg_data       = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];
    end

endmodule

// File: tb/tb_bubble_fetch_decode.sv
// Scoreboard bench for bubble_fetch_decode: expected fetches, alu operands and halts
// are queued as stimulus is issued; a monitor pops and compares as the DUT presents them.
module tb_bubble_fetch_decode;

    logic        clk = 1'b0;
    logic        rst, start, start2;
    logic        busy, halted, illegal, busy2, halted2, illegal2;
    logic [31:0] retired, retired2, dbg_data, dbg_data2;
    logic [4:0]  dbg_addr, dbg_addr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bubble_fetch_decode_if bus ();
    bubble_fetch_decode_if bus2 ();

    bubble_fetch_decode #(.RESET_PC(16'd0), .HALT_OPCODE(6'd63)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .halted(halted),
        .illegal(illegal), .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    bubble_fetch_decode #(.RESET_PC(16'hFFFF), .HALT_OPCODE(6'd63)) dut_wrap (
        .clk(clk), .rst(rst), .start(start2), .bus(bus2), .busy(busy2), .halted(halted2),
        .illegal(illegal2), .retired(retired2), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
    );

    // Stub alu: add for immediates, s1+s2 for R-type; fixed targets for ops 7 and 15.
    assign bus.alu_dest   = (bus.alu_opcode == 6'd0) ? bus.alu_s1 + bus.alu_s2
                                                     : bus.alu_s1 + {16'd0, bus.alu_const};
    assign bus.alu_pc_new = (bus.alu_opcode == 6'd7)  ? 16'd1000 :
                            (bus.alu_opcode == 6'd15) ? 16'd512 : bus.alu_pc;
    assign bus2.alu_dest   = bus2.alu_s1 + {16'd0, bus2.alu_const};
    assign bus2.alu_pc_new = bus2.alu_pc;

    typedef struct packed { logic [15:0] addr; logic [31:0] ret; } fetch_exp_t;
    typedef struct packed { logic [5:0] op; logic [31:0] s1; logic [31:0] s2; logic [15:0] pc; } alu_exp_t;
    typedef struct packed { logic ill; logic [31:0] ret; } halt_exp_t;

    fetch_exp_t fq[$];
    alu_exp_t   aq[$];
    halt_exp_t  hq[$];

    logic [31:0] imem [int];
    int          stall = 0;
    logic        late_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] c);
        return {op, rs, rt, c};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 1'b0, 5'd0};
    endfunction

    task automatic exp_fetch(input logic [15:0] a, input logic [31:0] r);
        fetch_exp_t e;
        e.addr = a; e.ret = r;
        fq.push_back(e);
    endtask

    task automatic exp_alu(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [15:0] pc);
        alu_exp_t e;
        e.op = op; e.s1 = s1; e.s2 = s2; e.pc = pc;
        aq.push_back(e);
    endtask

    task automatic exp_halt(input logic ill, input logic [31:0] r);
        halt_exp_t e;
        e.ill = ill; e.ret = r;
        hq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic read_rf(input logic [4:0] a, input logic [31:0] exp, input string name);
        dbg_addr = a;
        #1;
        check(name, dbg_data, exp);
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        check("halt reached", {31'd0, halted}, 32'd1);
    endtask

    // Instruction memory responders: answer after 'stall' wait cycles.
    initial begin
        int cnt = 0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'd0;
        forever begin
            step();
            if (bus.imem_req) begin
                bus.imem_valid = (cnt >= stall);
                cnt++;
            end else begin
                bus.imem_valid = late_valid;
                cnt = 0;
            end
            bus.imem_rdata = imem.exists(int'(bus.imem_addr)) ? imem[int'(bus.imem_addr)] : 32'd0;
        end
    end

    initial begin
        bus2.imem_valid = 1'b0;
        bus2.imem_rdata = 32'd0;
        forever begin
            step();
            bus2.imem_valid = bus2.imem_req;
            bus2.imem_rdata = enc_i(6'd1, 5'd0, 5'd1, 16'd7);
        end
    end

    // Monitor: new fetch requests, EXEC-cycle operands and halt entry.
    initial begin
        logic req_prev = 1'b0;
        logic halt_prev = 1'b0;
        int   exec_cnt = 0;
        fetch_exp_t fe;
        alu_exp_t   ae;
        halt_exp_t  he;
        forever begin
            @(negedge clk);
            if (rst) begin
                exec_cnt = 0;
            end else begin
                if (exec_cnt != 0) begin
                    exec_cnt--;
                    if (exec_cnt == 0 && busy) begin
                        if (aq.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected exec: opcode %0d with no entry queued",
                                     bus.alu_opcode);
                        end else begin
                            ae = aq.pop_front();
                            check("exec alu_opcode", {26'd0, bus.alu_opcode}, {26'd0, ae.op});
                            check("exec alu_s1", bus.alu_s1, ae.s1);
                            check("exec alu_s2", bus.alu_s2, ae.s2);
                            check("exec alu_pc", {16'd0, bus.alu_pc}, {16'd0, ae.pc});
                        end
                    end
                end
                if (bus.imem_req && !req_prev) begin
                    if (fq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected fetch: addr %0d with no entry queued",
                                 bus.imem_addr);
                    end else begin
                        fe = fq.pop_front();
                        check("fetch imem_addr", {16'd0, bus.imem_addr}, {16'd0, fe.addr});
                        check("fetch retired", retired, fe.ret);
                    end
                end
                if (halted && !halt_prev) begin
                    if (hq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected halt: retired %0d with no entry queued", retired);
                    end else begin
                        he = hq.pop_front();
                        check("halt illegal", {31'd0, illegal}, {31'd0, he.ill});
                        check("halt retired", retired, he.ret);
                    end
                end
                if (bus.imem_req && bus.imem_valid) exec_cnt = 2;
            end
            req_prev  = bus.imem_req;
            halt_prev = halted;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; dbg_addr = 5'd0; dbg_addr2 = 5'd0;

        // Reset and idle.
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        check("idle pc", {16'd0, bus.imem_addr}, 32'd0);
        check("idle imem_req", {31'd0, bus.imem_req}, 32'd0);
        check("idle busy", {31'd0, busy}, 32'd0);
        check("idle halted", {31'd0, halted}, 32'd0);
        check("idle retired", retired, 32'd0);
        check("idle alu_s1", bus.alu_s1, 32'd0);
        for (int i = 0; i < 32; i++) read_rf(5'(i), 32'd0, "idle rf");

        // Immediate then R-type, then HALT.
        imem[0] = enc_i(6'd1, 5'd0, 5'd1, 16'd123);
        imem[1] = enc_i(6'd1, 5'd0, 5'd2, 16'd23);
        imem[2] = enc_r(5'd1, 5'd2, 5'd3);
        imem[3] = {6'd63, 26'd0};
        exp_fetch(16'd0, 32'd0); exp_alu(6'd1, 32'd0, 32'd0, 16'd1);
        exp_fetch(16'd1, 32'd1); exp_alu(6'd1, 32'd0, 32'd0, 16'd2);
        exp_fetch(16'd2, 32'd2); exp_alu(6'd0, 32'd123, 32'd23, 16'd3);
        exp_fetch(16'd3, 32'd3);
        exp_halt(1'b0, 32'd3);
        pulse_start();
        wait_halt(200);
        step();
        read_rf(5'd1, 32'd123, "rf1 imm");
        read_rf(5'd2, 32'd23, "rf2 imm");
        read_rf(5'd3, 32'd146, "rf3 rtype");
        check("halt pc", {16'd0, bus.imem_addr}, 32'd3);
        pulse_start();
        repeat (3) step();
        check("halt ignores start: halted", {31'd0, halted}, 32'd1);
        check("halt ignores start: req", {31'd0, bus.imem_req}, 32'd0);
        check("halt ignores start: retired", retired, 32'd3);

        // Reg0 write, branch, jump-and-link, illegal opcode.
        do_reset();
        check("reset clears halted", {31'd0, halted}, 32'd0);
        check("reset clears retired", retired, 32'd0);
        imem[0]    = enc_i(6'd1, 5'd0, 5'd1, 16'd5);
        imem[1]    = enc_i(6'd1, 5'd0, 5'd0, 16'd55);
        imem[2]    = enc_r(5'd1, 5'd1, 5'd4);
        imem[3]    = enc_i(6'd1, 5'd4, 5'd5, 16'd1);
        imem[4]    = enc_i(6'd7, 5'd1, 5'd4, 16'd0);
        imem[1000] = {6'd15, 26'd0};
        imem[512]  = {6'd20, 26'd0};
        exp_fetch(16'd0, 32'd0);    exp_alu(6'd1, 32'd0, 32'd0, 16'd1);
        exp_fetch(16'd1, 32'd1);    exp_alu(6'd1, 32'd0, 32'd0, 16'd2);
        exp_fetch(16'd2, 32'd2);    exp_alu(6'd0, 32'd5, 32'd5, 16'd3);
        exp_fetch(16'd3, 32'd3);    exp_alu(6'd1, 32'd10, 32'd0, 16'd4);
        exp_fetch(16'd4, 32'd4);    exp_alu(6'd7, 32'd5, 32'd10, 16'd5);
        exp_fetch(16'd1000, 32'd5); exp_alu(6'd15, 32'd0, 32'd0, 16'd1001);
        exp_fetch(16'd512, 32'd6);
        exp_halt(1'b1, 32'd6);
        pulse_start();
        wait_halt(300);
        step();
        read_rf(5'd0, 32'd0, "rf0 stays zero");
        read_rf(5'd1, 32'd5, "rf1");
        read_rf(5'd4, 32'd10, "rf4");
        read_rf(5'd5, 32'd11, "rf5");
        read_rf(5'd31, 32'd1001, "rf31 link");
        check("illegal sticky", {31'd0, illegal}, 32'd1);
        check("illegal retired", retired, 32'd6);

        // Fetch stall of 7 cycles, then reset during a stall.
        do_reset();
        check("reset clears illegal", {31'd0, illegal}, 32'd0);
        imem[0] = enc_i(6'd1, 5'd0, 5'd1, 16'd9);
        imem[1] = enc_i(6'd1, 5'd0, 5'd2, 16'd3);
        stall = 7;
        exp_fetch(16'd0, 32'd0); exp_alu(6'd1, 32'd0, 32'd0, 16'd1);
        exp_fetch(16'd1, 32'd1);
        pulse_start();
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            if (!bus.imem_req) lows++;
            step();
        end
        check("stall req held low cycles", 32'(lows), 32'd0);
        step(); step();
        check("stall not retired at 10", retired, 32'd0);
        step();
        check("stall retired at 11", retired, 32'd1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        late_valid = 1'b1;
        repeat (3) step();
        late_valid = 1'b0;
        step();
        check("mid-fetch reset pc", {16'd0, bus.imem_addr}, 32'd0);
        check("mid-fetch reset busy", {31'd0, busy}, 32'd0);
        check("mid-fetch reset req", {31'd0, bus.imem_req}, 32'd0);
        check("mid-fetch reset retired", retired, 32'd0);
        read_rf(5'd1, 32'd0, "mid-fetch reset rf1");
        stall = 0;
        step();
        check("fetch queue drained", 32'(fq.size()), 32'd0);
        check("alu queue drained", 32'(aq.size()), 32'd0);
        check("halt queue drained", 32'(hq.size()), 32'd0);

        // PC wrap from RESET_PC = 16'hFFFF.
        do_reset();
        check("wrap reset pc", {16'd0, bus2.imem_addr}, 32'h0000FFFF);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("wrap fetch req", {31'd0, bus2.imem_req}, 32'd1);
        check("wrap fetch addr", {16'd0, bus2.imem_addr}, 32'h0000FFFF);
        check("wrap alu_pc before", {16'd0, bus2.alu_pc}, 32'd0);
        repeat (4) step();
        check("wrap next req", {31'd0, bus2.imem_req}, 32'd1);
        check("wrap next addr", {16'd0, bus2.imem_addr}, 32'd0);
        check("wrap retired", retired2, 32'd1);
        dbg_addr2 = 5'd1;
        #1;
        check("wrap rf1", dbg_data2, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bubble_fetch_decode.md
Name: bubble_fetch_decode

Overview:
- Multi-cycle front end and control for the BUBBLE processor; sits directly upstream of the alu.
- Fetches 32-bit instructions from instruction memory over a req/valid handshake and decodes the fields.
- Reads the internal 32x32 register file, drives the alu operand ports, then writes back alu results and updates the PC from either PC+1 or the alu's pcNew.

Parameters:
- RESET_PC, 16'd0, PC value loaded on reset.
- HALT_OPCODE, 6'd63, opcode that stops execution.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching at current PC.
- imem_req  out  1  fetch request; held high in FETCH.
- imem_addr  out  16  word address of the instruction; equals PC.
- imem_valid  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- alu_opcode  out  6  instr[31:26].
- alu_funct  out  5  instr[4:0]; instr[5] ignored.
- alu_shamt  out  5  instr[10:6].
- alu_s1  out  32  RF[rs], where rs = instr[25:21].
- alu_s2  out  32  RF[rt], where rt = instr[20:16].
- alu_pc  out  16  PC+1 of the current instruction.
- alu_const  out  16  instr[15:0].
- alu_jump  out  26  instr[25:0].
- alu_dest  in  32  alu result.
- alu_pc_new  in  16  alu branch/jump target.
- busy  out  1  high in FETCH, DECODE, EXEC and WB.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when an unknown opcode causes the halt.
- retired  out  32  count of completed instructions.
- dbg_addr  in  5  debug register select.
- dbg_data  out  32  RF[dbg_addr]; combinational; 0 when dbg_addr = 0.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE; PC = RESET_PC.
  - All RF entries, retired, illegal and halted are cleared.
  - imem_req = 0 and all alu_* outputs = 0.
  - Reset overrides any state, including an outstanding fetch. An imem_valid arriving after reset is ignored.
- FSM states are IDLE, FETCH, DECODE, EXEC, WB and HALT.
  - IDLE: outputs held. start=1 moves to FETCH.
  - FETCH: imem_req=1 and imem_addr=PC. On an edge with imem_valid=1, latch imem_rdata into IR, drop imem_req, and move to DECODE. Otherwise stay, with no timeout.
  - DECODE:
    - If opcode = HALT_OPCODE, move to HALT. retired is not incremented.
    - If the opcode is in 16..62, set illegal=1 and move to HALT.
    - Otherwise register all alu_* outputs from IR and the RF and move to EXEC.
  - EXEC: alu_* outputs held stable for the whole cycle. At the end of the cycle, capture alu_dest and alu_pc_new into internal registers, then move to WB.
  - WB: perform the per-class action below, increment retired, and move to FETCH.
  - HALT: halted=1; remains until rst. start is ignored.
- Opcode classes in WB (PC arithmetic is 16-bit and wraps, so 16'hFFFF+1 = 0):
  - 0 (R-type): RF[rd] = dest, where rd = instr[15:11]. PC = PC+1.
  - 1..6 (immediate): RF[rt] = dest. PC = PC+1.
  - 7..12 (branch): no RF write. PC = captured pc_new; the alu returns PC+1 when the branch is not taken.
  - 13..14 (jump): no RF write. PC = pc_new.
  - 15 (jump-and-link): RF[31] = zero-extended PC+1. PC = pc_new.
- Register 0:
  - Writes to register 0 are dropped.
  - Reads of register 0 always return 0.
  - RF reads in DECODE see all prior writebacks, so no forwarding is needed.
- Latency: 4 cycles per instruction when imem_valid is high in the first FETCH cycle; each extra FETCH wait cycle adds 1.
- retired wraps at 2^32.

Test Plan:
- Reset and idle: assert rst for 2 cycles with start=0, then run 5 cycles -> PC=0, imem_req=0, busy=0, halted=0, retired=0, dbg_data=0 for every address.
- Immediate then R-type, with a stub alu returning dest = s1 + const for opcode 1 and s1 + s2 for opcode 0:
  - Program: {op1, rs0, rt1, const 123}, {op1, rs0, rt2, const 23}, {op0, rs1, rt2, rd3, funct0}, HALT.
  - Required: RF1=123, RF2=23, RF3=146, retired=3, halted=1, last PC=3.
  - During the R-type EXEC cycle: alu_s1=123, alu_s2=23, alu_pc=3.
- Branch and jump-and-link:
  - Op 7 at PC=4 with stub pc_new=1000 -> next imem_addr=1000.
  - Op 15 at PC=1000 with pc_new=512 -> RF31=1001 and next imem_addr=512.
- Fetch stall and reset mid-fetch:
  - Hold imem_valid low for 7 cycles -> imem_req stays high and the instruction retires 11 cycles after FETCH entry.
  - Assert rst during a stall -> IDLE, PC=0; a late imem_valid is ignored.
- Illegal and reg0:
  - {op1, rt0, const 55} -> RF0 stays 0 and retired increments.
  - Opcode 20 -> illegal=1, halted=1, and retired is unchanged.
  - start pulses while in HALT -> no effect.
- PC wrap: RESET_PC=16'hFFFF with a non-branch instruction -> next imem_addr=0.
